// File: rtl/fib_index.sv
// rtl/fib_index.sv - inverse Fibonacci search: smallest n with F(n) >= target
// Walks F(k) upward one step per cycle from k=1; saturates at F(30), the largest 20-bit term.
module fib_index (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_index,
  output logic [19:0] out_value,
  output logic        out_is_fib,
  output logic        out_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]  K_MAX = 8'd30;
  localparam logic [19:0] F_MAX = 20'd832040;

  state_t      state, state_next;
  logic [19:0] tgt, a, b;
  logic [7:0]  k;

  logic        load, step, finish;
  logic [7:0]  res_index;
  logic [19:0] res_value;
  logic        res_is_fib, res_overflow;

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    res_index    = 8'd0;
    res_value    = 20'd0;
    res_is_fib   = 1'b0;
    res_overflow = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Target 0 is checked first since the walk starts at F(1).
        if (tgt == 20'd0) begin
          finish     = 1'b1;
          res_is_fib = 1'b1;
          state_next = DONE;
        end else if (b >= tgt) begin
          finish     = 1'b1;
          res_index  = k;
          res_value  = b;
          res_is_fib = (b == tgt);
          state_next = DONE;
        end else if (k == K_MAX) begin
          finish       = 1'b1;
          res_index    = K_MAX;
          res_value    = F_MAX;
          res_overflow = 1'b1;
          state_next   = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tgt          <= 20'd0;
      a            <= 20'd0;
      b            <= 20'd1;
      k            <= 8'd1;
      out_index    <= 8'd0;
      out_value    <= 20'd0;
      out_is_fib   <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        tgt <= in_target;
        a   <= 20'd0;
        b   <= 20'd1;
        k   <= 8'd1;
      end
      // Stepping stops at k=30, so a+b never exceeds F(30) and cannot wrap.
      if (step) begin
        a <= b;
        b <= a + b;
        k <= k + 8'd1;
      end
      if (finish) begin
        out_index    <= res_index;
        out_value    <= res_value;
        out_is_fib   <= res_is_fib;
        out_overflow <= res_overflow;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fib_index.sv
// tb/tb_fib_index.sv - directed and sweep bench for fib_index with a result scoreboard
module tb_fib_index;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_index;
  logic [19:0] out_value;
  logic        out_is_fib;
  logic        out_overflow;

  fib_index dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_target    (in_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_value    (out_value),
    .out_is_fib   (out_is_fib),
    .out_overflow (out_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  idx;
    logic [19:0] val;
    logic        fib;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [19:0] t);
    int   f[31];
    exp_t e;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= 30; i++) f[i] = f[i-1] + f[i-2];
    for (int i = 0; i <= 30; i++) begin
      if (f[i] >= int'(t)) begin
        e.idx = 8'(i);
        e.val = 20'(f[i]);
        e.fib = (f[i] == int'(t));
        e.ovf = 1'b0;
        return e;
      end
    end
    e.idx = 8'd30;
    e.val = 20'(f[30]);
    e.fib = 1'b0;
    e.ovf = 1'b1;
    return e;
  endfunction

  task automatic accept(input logic [19:0] t);
    int cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_target = t;
    @(posedge clock);
    q.push_back(model(t));
    @(negedge clock);
    in_valid  = 1'b0;
    in_target = 20'($urandom);
  endtask

  task automatic collect(input string tag);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, q.size(), 1);
    end else begin
      e = q.pop_front();
      check({tag, "_latency"}, lat, (e.idx > 0) ? e.idx : 1);
      check({tag, "_index"}, out_index, e.idx);
      check({tag, "_value"}, out_value, e.val);
      check({tag, "_is_fib"}, out_is_fib, e.fib);
      check({tag, "_overflow"}, out_overflow, e.ovf);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, in_ready, 1);
    check({tag, "_idle_out_valid"}, out_valid, 0);
  endtask

  task automatic run_one(input string tag, input logic [19:0] t);
    accept(t);
    collect(tag);
    consume(tag);
  endtask

  initial begin
    logic [7:0]  held_idx;
    logic [19:0] held_val;
    int          seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_target = 20'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_is_fib", out_is_fib, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_in_ready", in_ready, 1);

    // Reset mid-search discards the target.
    accept(20'd832040);
    repeat (10) @(negedge clock);
    check("midrun_in_ready_low", in_ready, 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    void'(q.pop_back());
    check("midrun_in_ready", in_ready, 1);
    seen = 0;
    repeat (35) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("midrun_no_out_valid", seen, 0);

    run_one("t0", 20'd0);
    run_one("t1", 20'd1);
    run_one("t5", 20'd5);
    run_one("t832040", 20'd832040);
    run_one("t4", 20'd4);
    run_one("t100", 20'd100);
    run_one("t2", 20'd2);
    run_one("t832041", 20'd832041);
    run_one("t1048575", 20'd1048575);

    out_ready = 1'b1;
    run_one("t3_ready_early", 20'd3);

    // Backpressure: result must hold and a new target must be refused.
    accept(20'd13);
    collect("t13");
    held_idx = 8'd7;
    held_val = 20'd13;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_valid  = 1'b1;
        in_target = 20'd3;
      end else begin
        in_valid  = 1'b0;
      end
      @(negedge clock);
      check($sformatf("hold%0d_out_valid", c), out_valid, 1);
      check($sformatf("hold%0d_index", c), out_index, held_idx);
      check($sformatf("hold%0d_value", c), out_value, held_val);
      check($sformatf("hold%0d_in_ready", c), in_ready, 0);
    end
    in_valid = 1'b0;
    consume("t13");
    repeat (3) @(negedge clock);
    check("hold_pulse_ignored", out_valid, 0);

    for (int t = 0; t <= 2000; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      accept(20'(t));
      collect($sformatf("sweep%0d", t));
      if (!out_ready) repeat ($urandom_range(0, 3)) @(negedge clock);
      consume($sformatf("sweep%0d", t));
    end

    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
